// File: rtl/seven_segment_capture.sv
// seven_segment_capture: rebuilds the 16-bit hex value shown on a scanned 4-digit seven-segment bus.
// Build option SEG_CAPTURE_DP_EN adds dp_value, the decimal points of the last published frame.
module seven_segment_capture #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  seg,
  input  logic        dp,
  input  logic [3:0]  an,
  output logic [15:0] value,
  output logic [3:0]  digit_valid,
  output logic        frame_done,
  output logic        decode_error
`ifdef SEG_CAPTURE_DP_EN
  ,
  output logic [3:0]  dp_value
`endif
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         r_cur_an;
  logic [3:0]         r_an;
  logic [6:0]         r_seg;
  logic [3:0]         r_pending;
  logic [15:0]        r_shadow;

  logic               w_an_legal;
  logic [1:0]         w_an_idx;
  logic               w_dec_ok;
  logic [3:0]         w_nib;
  logic               w_changed;
  logic               w_capture;
  logic [3:0]         w_sel;
  logic [3:0]         w_pend_next;
  logic [15:0]        w_merged;

  // Anode qualification: exactly one active-low enable selects a digit
  always_comb begin
    w_an_legal = 1'b0;
    w_an_idx   = 2'd0;
    case (r_an)
      4'b1110: begin w_an_legal = 1'b1; w_an_idx = 2'd0; end
      4'b1101: begin w_an_legal = 1'b1; w_an_idx = 2'd1; end
      4'b1011: begin w_an_legal = 1'b1; w_an_idx = 2'd2; end
      4'b0111: begin w_an_legal = 1'b1; w_an_idx = 2'd3; end
      default: begin w_an_legal = 1'b0; w_an_idx = 2'd0; end
    endcase
  end

  // Segment pattern {g..a}, active low, back to a hex nibble
  always_comb begin
    w_dec_ok = 1'b1;
    w_nib    = 4'h0;
    case (r_seg)
      7'h40: w_nib = 4'h0;
      7'h79: w_nib = 4'h1;
      7'h24: w_nib = 4'h2;
      7'h30: w_nib = 4'h3;
      7'h19: w_nib = 4'h4;
      7'h12: w_nib = 4'h5;
      7'h02: w_nib = 4'h6;
      7'h78: w_nib = 4'h7;
      7'h00: w_nib = 4'h8;
      7'h10: w_nib = 4'h9;
      7'h08: w_nib = 4'hA;
      7'h03: w_nib = 4'hB;
      7'h46: w_nib = 4'hC;
      7'h21: w_nib = 4'hD;
      7'h06: w_nib = 4'hE;
      7'h0E: w_nib = 4'hF;
      default: begin w_dec_ok = 1'b0; w_nib = 4'h0; end
    endcase
  end

  // A new dwell starts whenever the anode differs from the one being tracked; that edge counts
  // as the first cycle seen, so capture lands once an_r has held SETTLE_CYCLES cycles.
  always_comb begin
    w_changed   = (r_state == IDLE) || (r_an != r_cur_an);
    w_capture   = (w_changed && w_an_legal && (SETTLE_CYCLES == 1)) ||
                  (!w_changed && (r_state == SETTLE) && (r_cnt == CNT_W'(SETTLE_CYCLES - 2)));
    w_sel       = 4'b0001 << w_an_idx;
    w_pend_next = r_pending | w_sel;
    w_merged    = r_shadow;
    for (int i = 0; i < 4; i++) begin
      if (w_an_idx == 2'(i)) w_merged[4*i +: 4] = w_nib;
    end
  end

  // Dwell tracking FSM plus capture and atomic frame publication
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_seg        <= 7'h7F;
      r_an         <= 4'hF;
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_cur_an     <= 4'hF;
      r_pending    <= 4'h0;
      r_shadow     <= 16'h0000;
      value        <= 16'h0000;
      digit_valid  <= 4'h0;
      frame_done   <= 1'b0;
      decode_error <= 1'b0;
    end else begin
      r_seg        <= seg;
      r_an         <= an;
      frame_done   <= 1'b0;
      decode_error <= 1'b0;

      if (w_changed) begin
        if (w_an_legal) begin
          r_state  <= (SETTLE_CYCLES == 1) ? HOLD : SETTLE;
          r_cnt    <= '0;
          r_cur_an <= r_an;
        end else begin
          r_state  <= IDLE;
        end
      end else if (r_state == SETTLE) begin
        if (w_capture) r_state <= HOLD;
        else           r_cnt   <= r_cnt + CNT_W'(1);
      end

      if (w_capture) begin
        if (w_dec_ok) begin
          r_shadow              <= w_merged;
          digit_valid[w_an_idx] <= 1'b1;
          if (w_pend_next == 4'hF) begin
            value      <= w_merged;
            r_pending  <= 4'h0;
            frame_done <= 1'b1;
          end else begin
            r_pending  <= w_pend_next;
          end
        end else begin
          decode_error          <= 1'b1;
          digit_valid[w_an_idx] <= 1'b0;
          r_pending             <= r_pending & ~w_sel;
        end
      end
    end
  end

`ifdef SEG_CAPTURE_DP_EN
  logic       r_dp;
  logic [3:0] r_dp_shadow;
  logic [3:0] w_dp_merged;

  assign w_dp_merged = (r_dp_shadow & ~w_sel) | (w_sel & {4{~r_dp}});

  // Decimal points ride along with every capture and publish with the frame
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dp        <= 1'b1;
      r_dp_shadow <= 4'h0;
      dp_value    <= 4'h0;
    end else begin
      r_dp <= dp;
      if (w_capture) begin
        r_dp_shadow <= w_dp_merged;
        if (w_dec_ok && (w_pend_next == 4'hF)) dp_value <= w_dp_merged;
      end
    end
  end
`else
  logic w_unused_dp;
  assign w_unused_dp = dp;
`endif

endmodule

// File: tb/tb_seven_segment_capture.sv
// Scoreboard bench for seven_segment_capture: expected frame/error events are queued as the scan is driven.
module tb_seven_segment_capture;

  logic        clock = 1'b0;
  logic        reset;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [15:0] value;
  logic [3:0]  digit_valid;
  logic        frame_done;
  logic        decode_error;
`ifdef SEG_CAPTURE_DP_EN
  logic [3:0]  dp_value;
`endif

  always #5 clock = ~clock;

  seven_segment_capture #(.SETTLE_CYCLES(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .seg          (seg),
    .dp           (dp),
    .an           (an),
    .value        (value),
    .digit_valid  (digit_valid),
    .frame_done   (frame_done),
`ifdef SEG_CAPTURE_DP_EN
    .decode_error (decode_error),
    .dp_value     (dp_value)
`else
    .decode_error (decode_error)
`endif
  );

  typedef struct packed {
    logic        is_err;
    logic [15:0] val;
    logic [3:0]  valid;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [3:0] an_of(input int d);
    case (d)
      0: return 4'b1110;
      1: return 4'b1101;
      2: return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  task automatic show(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
    an  = a;
    seg = s;
    dp  = d;
    repeat (n) @(negedge clock);
  endtask

  task automatic scan(input logic [15:0] v, input int dwell, input logic [3:0] mask,
                      input logic [3:0] dp_lit);
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) show(an_of(i), seg_of(v[4*i +: 4]), ~dp_lit[i], dwell);
    end
    show(4'hF, 7'h7F, 1'b1, 8);
  endtask

  task automatic push_frame(input logic [15:0] v, input logic [3:0] valid);
    exp_q.push_back('{is_err: 1'b0, val: v, valid: valid});
  endtask

  task automatic push_err(input logic [3:0] valid);
    exp_q.push_back('{is_err: 1'b1, val: 16'h0000, valid: valid});
  endtask

  task automatic drain(input string tag);
    check_eq(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Output monitor: every pulse must match the next queued expectation
  always @(negedge clock) begin : monitor
    ev_t e;
    if (!reset && (frame_done || decode_error)) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_event", 32'({frame_done, decode_error}), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("event_kind", 32'({frame_done, decode_error}), e.is_err ? 32'd1 : 32'd2);
        if (!e.is_err) check_eq("frame_value", 32'(value), 32'(e.val));
        check_eq("event_valid", 32'(digit_valid), 32'(e.valid));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    an    = 4'hF;
    seg   = 7'h7F;
    dp    = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("rst_value", 32'(value), 32'd0);
    check_eq("rst_valid", 32'(digit_valid), 32'd0);
    check_eq("rst_pulses", 32'({frame_done, decode_error}), 32'd0);
`ifdef SEG_CAPTURE_DP_EN
    check_eq("rst_dp_value", 32'(dp_value), 32'd0);
`endif
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Basic 8-cycle scan, dp lit on digit1
    push_frame(16'h1234, 4'hF);
    scan(16'h1234, 8, 4'hF, 4'b0010);
    drain("s1_drain");
    check_eq("s1_value", 32'(value), 32'h1234);
    check_eq("s1_valid", 32'(digit_valid), 32'hF);
`ifdef SEG_CAPTURE_DP_EN
    check_eq("s1_dp_value", 32'(dp_value), 32'b0010);
`endif

    // Dwell too short for capture, then just long enough
    scan(16'h5678, 3, 4'hF, 4'h0);
    drain("s2_short_drain");
    check_eq("s2_hold_value", 32'(value), 32'h1234);
    push_frame(16'h5678, 4'hF);
    scan(16'h5678, 4, 4'hF, 4'h0);
    drain("s2_drain");
    check_eq("s2_value", 32'(value), 32'h5678);

    // Illegal anode stretches between digits
    push_frame(16'hABCD, 4'hF);
    for (int i = 0; i < 4; i++) begin
      show(an_of(i), seg_of(4'(16'hABCD >> (4*i))), 1'b1, 8);
      show((i % 2 == 1) ? 4'b1100 : 4'b1111, seg_of(4'h8), 1'b1, 20);
    end
    drain("s3_drain");
    check_eq("s3_value", 32'(value), 32'hABCD);

    // Undecodable digit2, then a clean rescan
    push_err(4'b1011);
    show(an_of(0), seg_of(4'h4), 1'b1, 8);
    show(an_of(1), seg_of(4'h3), 1'b1, 8);
    show(an_of(2), 7'h7F, 1'b1, 8);
    show(an_of(3), seg_of(4'h1), 1'b1, 8);
    show(4'hF, 7'h7F, 1'b1, 8);
    drain("s4_err_drain");
    check_eq("s4_err_valid", 32'(digit_valid), 32'b1011);
    check_eq("s4_err_value", 32'(value), 32'hABCD);
    push_frame(16'h1E34, 4'hF);
    scan(16'h1E34, 8, 4'hF, 4'h0);
    drain("s4_drain");
    check_eq("s4_value", 32'(value), 32'h1E34);

    // Reset mid-frame discards partial captures
    scan(16'h0077, 8, 4'b0011, 4'h0);
    drain("s5_partial_drain");
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check_eq("s5_rst_value", 32'(value), 32'd0);
    check_eq("s5_rst_valid", 32'(digit_valid), 32'd0);
    check_eq("s5_rst_pulses", 32'({frame_done, decode_error}), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    scan(16'hC0DE, 8, 4'b1100, 4'h0);
    drain("s5_half_drain");
    check_eq("s5_half_valid", 32'(digit_valid), 32'b1100);
    check_eq("s5_half_value", 32'(value), 32'd0);
    push_frame(16'hC0DE, 4'hF);
    scan(16'hC0DE, 8, 4'hF, 4'h0);
    drain("s5_drain");
    check_eq("s5_value", 32'(value), 32'hC0DE);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
